game_flow_ctrl: RTL

Parametrised game-flow controller, the next generation of the single-life begin/continue/lost/won game FSM. It adds multiple lives, multiple levels, invulnerability after a hit and timed result screens. Collision and screen-end detection are folded in, sampled per pixel and resolved once per frame. It sits between the pixel/draw datapath (x, colour) and the renderer/score logic, which consume state, lives and level.

---
 rtl/game_pkg.sv | 23 ++
 rtl/frame_event_latch.sv | 44 ++++
 rtl/game_flow_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the game-flow controller: state encoding, state width and
// the default obstacle colour.
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_BEGIN    = 3'd0,
        S_PLAY     = 3'd1,
        S_HIT      = 3'd2,
        S_LEVEL_UP = 3'd3,
        S_LOST     = 3'd4,
        S_WON      = 3'd5,
        S_PAUSED   = 3'd6
    } state_e;

    localparam logic [2:0] COLLIDE_COLOUR_DEF = 3'b010;

    function automatic logic is_run(input state_e s);
        return (s == S_PLAY) || (s == S_HIT);
    endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Per-pixel collision / screen-end sampling, accumulated over one frame and
// resolved by the controller on frame_tick.
module frame_event_latch #(
    parameter int         X_W            = 8,
    parameter int         X_END          = 159,
    parameter logic [2:0] COLLIDE_COLOUR = 3'b010
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           hit_en,
    input  logic           end_en,
    input  logic           pixel_valid,
    input  logic [X_W-1:0] pixel_x,
    input  logic [2:0]     pixel_colour,
    output logic           hit_now,
    output logic           end_now
);

    logic hit_flag_q, hit_flag_d;
    logic end_flag_q, end_flag_d;
    logic hit_sample, end_sample;

    always_comb begin
        hit_sample = pixel_valid && hit_en && (pixel_colour == COLLIDE_COLOUR);
        end_sample = pixel_valid && end_en && (pixel_x >= X_W'(X_END));
        // A sample landing on the tick cycle still counts for this frame.
        hit_now    = hit_flag_q | hit_sample;
        end_now    = end_flag_q | end_sample;
        hit_flag_d = clear ? 1'b0 : hit_now;
        end_flag_d = clear ? 1'b0 : end_now;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_flag_q <= 1'b0;
            end_flag_q <= 1'b0;
        end else begin
            hit_flag_q <= hit_flag_d;
            end_flag_q <= end_flag_d;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Multi-life, multi-level game-flow FSM with invulnerability and timed result
// screens. Optional pause support is enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int         LIVES          = 3,
    parameter int         LIFE_W         = 2,
    parameter int         NUM_LEVELS     = 4,
    parameter int         LVL_W          = 2,
    parameter int         X_W            = 8,
    parameter int         X_END          = 159,
    parameter logic [2:0] COLLIDE_COLOUR = COLLIDE_COLOUR_DEF,
    parameter int         HIT_FRAMES     = 30,
    parameter int         RESULT_FRAMES  = 60
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               user_input,
    input  logic               pause_req,
    input  logic               pixel_valid,
    input  logic [X_W-1:0]     pixel_x,
    input  logic [2:0]         pixel_colour,
    output logic [STATE_W-1:0] state,
    output logic [LIFE_W-1:0]  lives,
    output logic [LVL_W-1:0]   level,
    output logic               game_active,
    output logic               won,
    output logic               lost
);

    localparam int TMR_MAX = (HIT_FRAMES > RESULT_FRAMES) ? HIT_FRAMES : RESULT_FRAMES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]  T_HIT      = TMR_W'(HIT_FRAMES);
    localparam logic [TMR_W-1:0]  T_RESULT   = TMR_W'(RESULT_FRAMES);
    localparam logic [TMR_W-1:0]  T_ONE      = TMR_W'(1);
    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
    localparam logic [LVL_W-1:0]  LAST_LVL   = LVL_W'(NUM_LEVELS - 1);

    state_e             state_q, state_d;
    logic [LIFE_W-1:0]  lives_q, lives_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               game_active_q, game_active_d;
    logic               won_q, won_d;
    logic               lost_q, lost_d;
    state_e             end_target;
    logic               hit_now, end_now;
    logic               flag_clr;

`ifdef GAME_PAUSE_EN
    state_e             ret_q, ret_d;
`else
    logic               unused_pause;
    assign unused_pause = pause_req;
`endif

    frame_event_latch #(
        .X_W            (X_W),
        .X_END          (X_END),
        .COLLIDE_COLOUR (COLLIDE_COLOUR)
    ) u_latch (
        .clock        (clock),
        .reset        (reset),
        .clear        (flag_clr),
        .hit_en       (state_q == S_PLAY),
        .end_en       (is_run(state_q)),
        .pixel_valid  (pixel_valid),
        .pixel_x      (pixel_x),
        .pixel_colour (pixel_colour),
        .hit_now      (hit_now),
        .end_now      (end_now)
    );

    assign flag_clr = frame_tick || (state_d != state_q);

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        timer_d    = timer_q;
        end_target = (level_q == LAST_LVL) ? S_WON : S_LEVEL_UP;
`ifdef GAME_PAUSE_EN
        ret_d      = ret_q;
`endif
        case (state_q)
            S_BEGIN: begin
                if (user_input) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_INIT;
                    level_d = '0;
                    timer_d = '0;
                end
            end
            S_PLAY, S_HIT: begin
                if (frame_tick) begin
                    if ((state_q == S_PLAY) && hit_now) begin
                        timer_d = (lives_q == LIFE_W'(1)) ? T_RESULT : T_HIT;
                        state_d = (lives_q == LIFE_W'(1)) ? S_LOST : S_HIT;
                        lives_d = lives_q - LIFE_W'(1);
                    end else if (end_now) begin
                        state_d = end_target;
                        timer_d = T_RESULT;
                    end else if (state_q == S_HIT) begin
                        if (timer_q == T_ONE) state_d = S_PLAY;
                        else                  timer_d = timer_q - T_ONE;
                    end
                end
            end
            S_LEVEL_UP: begin
                if (frame_tick) begin
                    if (timer_q == T_ONE) begin
                        state_d = S_PLAY;
                        level_d = level_q + LVL_W'(1);
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
            end
            S_LOST, S_WON: begin
                if (frame_tick) begin
                    if (timer_q == T_ONE) state_d = S_BEGIN;
                    else                  timer_d = timer_q - T_ONE;
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSED: begin
                if (pause_req) state_d = ret_q;
            end
`endif
            default: state_d = S_BEGIN;
        endcase
`ifdef GAME_PAUSE_EN
        // The frame decision is applied first; pause is taken from its result.
        if (pause_req && is_run(state_q) && is_run(state_d)) begin
            ret_d   = state_d;
            state_d = S_PAUSED;
        end
`endif
        game_active_d = is_run(state_d);
        won_d         = (state_d == S_WON);
        lost_d        = (state_d == S_LOST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_BEGIN;
            lives_q       <= '0;
            level_q       <= '0;
            timer_q       <= '0;
            game_active_q <= 1'b0;
            won_q         <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            timer_q       <= timer_d;
            game_active_q <= game_active_d;
            won_q         <= won_d;
            lost_q        <= lost_d;
        end
    end

`ifdef GAME_PAUSE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ret_q <= S_PLAY;
        else       ret_q <= ret_d;
    end
`endif

    assign state       = state_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign game_active = game_active_q;
    assign won         = won_q;
    assign lost        = lost_q;

endmodule
